// File: rtl/dbus_bridge_if.sv
// Bus bundles for dbus_bridge.
//   dbus_if : core D-port <-> bridge. master = CPU core, slave = bridge.
//   sbus_if : bridge <-> DM/DEV0/DEV1. master = bridge, slave = the three targets.
// Port summary:
//   dbus_if : DAddr/DREn/DWEn/DByteEn/DWData toward the bridge; DRData/DReady/DErr back to the core.
//   sbus_if : s_addr/s_wen/s_byteen/s_wdata/s_req toward the slaves; s_ack/s_rdata0..2 back.

interface dbus_if;
  logic [31:0] DAddr;
  logic        DREn;
  logic        DWEn;
  logic [3:0]  DByteEn;
  logic [31:0] DWData;
  logic [31:0] DRData;
  logic        DReady;
  logic        DErr;

  modport master (
    output DAddr, DREn, DWEn, DByteEn, DWData,
    input  DRData, DReady, DErr
  );

  modport slave (
    input  DAddr, DREn, DWEn, DByteEn, DWData,
    output DRData, DReady, DErr
  );
endinterface

interface sbus_if;
  logic [31:0] s_addr;
  logic        s_wen;
  logic [3:0]  s_byteen;
  logic [31:0] s_wdata;
  logic [2:0]  s_req;
  logic [2:0]  s_ack;
  logic [31:0] s_rdata0;
  logic [31:0] s_rdata1;
  logic [31:0] s_rdata2;

  modport master (
    output s_addr, s_wen, s_byteen, s_wdata, s_req,
    input  s_ack, s_rdata0, s_rdata1, s_rdata2
  );

  modport slave (
    input  s_addr, s_wen, s_byteen, s_wdata, s_req,
    output s_ack, s_rdata0, s_rdata1, s_rdata2
  );
endinterface

// File: rtl/dbus_bridge.sv
// Purpose: decode core D-port accesses to DM / DEV0 / DEV1 and collect slave IRQs into HWINT.
// Latency: DReady 2 cycles after an illegal request, 3 after a zero-wait slave, +1 per ack-wait cycle.
// Backpressure: core holds its request until DReady; slave stalls by withholding s_ack, bounded by TIMEOUT.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   core (dbus_if)  : core D-port, one access in flight, DReady pulses one cycle
//   sbus (sbus_if)  : registered one-hot req/ack bus toward the three slaves
//   dev_irq, ext_irq: interrupt levels; HWINT is their registered copy
//
// TIMEOUT must be >= 2. The three windows are assumed not to overlap.

module dbus_bridge #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] DM_TOP    = 32'h0000_2FFF,
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
  input  logic       clk,
  input  logic       reset,
  dbus_if.slave      core,
  sbus_if.master     sbus,
  input  logic [1:0] dev_irq,
  input  logic       ext_irq,
  output logic [5:0] HWINT
);

  localparam int unsigned     CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  // Device windows are 12 bytes, decoded inclusively as base..base+11.
  localparam logic [31:0]     DEV_LAST = 32'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic        s_wen_q, s_wen_d;
  logic [3:0]  s_byteen_q, s_byteen_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [2:0]  s_req_q, s_req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] drdata_q, drdata_d;
  logic        derr_q, derr_d;
  logic [5:0]  hwint_q;

  // Address decode and legality of the access presented by the core.
  logic        hit_dm, hit_d0, hit_d1, hit_dev, mapped, illegal, req_seen;
  logic [2:0]  sel;

  always_comb begin
    hit_dm   = (core.DAddr <= DM_TOP);
    hit_d0   = (core.DAddr >= DEV0_BASE) && (core.DAddr <= (DEV0_BASE + DEV_LAST));
    hit_d1   = (core.DAddr >= DEV1_BASE) && (core.DAddr <= (DEV1_BASE + DEV_LAST));
    hit_dev  = hit_d0 | hit_d1;
    sel      = {hit_d1, hit_d0, hit_dm};
    mapped   = |sel;
    req_seen = core.DREn | core.DWEn;
    // Timers only accept full-word writes; DM accepts any non-empty lane mask.
    illegal  = (core.DREn & core.DWEn)
             | ~mapped
             | (core.DWEn & (core.DByteEn == 4'h0))
             | (core.DWEn & hit_dev & (core.DByteEn != 4'hF));
  end

  // Only the selected lane's ack and data matter; s_req_q is one-hot in WAIT.
  logic        ack_hit;
  logic [31:0] rdata_sel;

  always_comb begin
    ack_hit   = |(sbus.s_ack & s_req_q);
    rdata_sel = ({32{s_req_q[0]}} & sbus.s_rdata0)
              | ({32{s_req_q[1]}} & sbus.s_rdata1)
              | ({32{s_req_q[2]}} & sbus.s_rdata2);
  end

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    s_addr_d   = s_addr_q;
    s_wen_d    = s_wen_q;
    s_byteen_d = s_byteen_q;
    s_wdata_d  = s_wdata_q;
    s_req_d    = s_req_q;
    cnt_d      = cnt_q;
    drdata_d   = drdata_q;
    derr_d     = derr_q;

    case (state_q)
      S_IDLE: begin
        if (req_seen) begin
          if (illegal) begin
            // Complete locally without touching the slave bus.
            derr_d   = 1'b1;
            drdata_d = 32'h0;
            state_d  = S_RESP;
          end else begin
            s_addr_d   = {core.DAddr[31:2], 2'b00};
            s_wen_d    = core.DWEn;
            s_byteen_d = core.DByteEn;
            s_wdata_d  = core.DWData;
            s_req_d    = sel;
            cnt_d      = '0;
            state_d    = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Core inputs are ignored here: a withdrawn request still completes.
        if (ack_hit) begin
          drdata_d = s_wen_q ? 32'h0 : rdata_sel;
          derr_d   = 1'b0;
          s_req_d  = 3'b000;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          drdata_d = 32'h0;
          derr_d   = 1'b1;
          s_req_d  = 3'b000;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        // Requests are not sampled here, so the core's still-held request
        // in the DReady cycle is not taken a second time.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        s_req_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      s_addr_q   <= 32'h0;
      s_wen_q    <= 1'b0;
      s_byteen_q <= 4'h0;
      s_wdata_q  <= 32'h0;
      s_req_q    <= 3'b000;
      cnt_q      <= '0;
      drdata_q   <= 32'h0;
      derr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_addr_q   <= s_addr_d;
      s_wen_q    <= s_wen_d;
      s_byteen_q <= s_byteen_d;
      s_wdata_q  <= s_wdata_d;
      s_req_q    <= s_req_d;
      cnt_q      <= cnt_d;
      drdata_q   <= drdata_d;
      derr_q     <= derr_d;
    end
  end

  // Interrupt collection runs every cycle regardless of the access FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      hwint_q <= 6'h00;
    end else begin
      hwint_q <= {3'b000, ext_irq, dev_irq[1], dev_irq[0]};
    end
  end

  // DRData/DErr hold between accesses; DReady is the only qualifier.
  assign core.DRData   = drdata_q;
  assign core.DErr     = derr_q;
  assign core.DReady   = (state_q == S_RESP);

  assign sbus.s_addr   = s_addr_q;
  assign sbus.s_wen    = s_wen_q;
  assign sbus.s_byteen = s_byteen_q;
  assign sbus.s_wdata  = s_wdata_q;
  assign sbus.s_req    = s_req_q;

  assign HWINT         = hwint_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Bench for dbus_bridge: directed steps followed by random accesses, each
// compared against expectations derived from the address map and timing rules.
module tb_dbus_bridge;

  localparam int          TO     = 16;
  localparam logic [31:0] DM_TOP = 32'h0000_2FFF;
  localparam logic [31:0] D0     = 32'h0000_7F00;
  localparam logic [31:0] D1     = 32'h0000_7F10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dev_irq = 2'b00;
  logic       ext_irq = 1'b0;
  logic [5:0] HWINT;

  dbus_if cif ();
  sbus_if sif ();

  int tests = 0;
  int fails = 0;

  // Slave environment knobs, set per access.
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [2:0]  junk_ack  = 3'b000;
  logic [31:0] dev0_dat  = 32'h0;
  logic [31:0] dev1_dat  = 32'h0;

  bit [31:0] mem     [0:3071];   // DM slave storage
  bit [31:0] ref_mem [0:3071];   // expected DM contents

  always #5 clk = ~clk;

  dbus_bridge #(
    .TIMEOUT  (TO),
    .DM_TOP   (DM_TOP),
    .DEV0_BASE(D0),
    .DEV1_BASE(D1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .core   (cif),
    .sbus   (sif),
    .dev_irq(dev_irq),
    .ext_irq(ext_irq),
    .HWINT  (HWINT)
  );

  // Slaves: ack the selected lane after ack_delay request cycles; spurious
  // acks appear on unselected lanes.
  always @(posedge clk) wait_cnt <= (sif.s_req != 3'b000) ? wait_cnt + 1 : 0;

  assign sif.s_ack = (((sif.s_req != 3'b000) && (wait_cnt >= ack_delay)) ? sif.s_req : 3'b000)
                   | (junk_ack & ~sif.s_req);
  assign sif.s_rdata0 = (sif.s_addr <= DM_TOP) ? mem[sif.s_addr[13:2]] : 32'h0;
  assign sif.s_rdata1 = dev0_dat;
  assign sif.s_rdata2 = dev1_dat;

  always @(posedge clk) begin
    if (sif.s_req[0] && sif.s_ack[0] && sif.s_wen) begin
      for (int i = 0; i < 4; i++)
        if (sif.s_byteen[i]) mem[sif.s_addr[13:2]][8*i +: 8] <= sif.s_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One core access; called right after a falling edge.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input int dly);
    logic        in_dm, in0, in1, legal;
    logic [2:0]  exp_sel;
    int          exp_lat, exp_cyc, n, cyc;
    logic        exp_err, got;
    logic [31:0] exp_dat;
    int          w;

    in_dm   = (addr <= DM_TOP);
    in0     = (addr >= D0) && ((addr - D0) < 12);
    in1     = (addr >= D1) && ((addr - D1) < 12);
    legal   = !(rd && wr) && (in_dm || in0 || in1) && !(wr && be == 4'h0)
              && !(wr && (in0 || in1) && be != 4'hF);
    exp_sel = in_dm ? 3'b001 : in0 ? 3'b010 : 3'b100;
    w       = int'(addr[13:2]);
    dev0_dat = $urandom;
    dev1_dat = $urandom;
    junk_ack = 3'($urandom_range(0, 7));
    ack_delay = dly;

    if (!legal) begin
      exp_lat = 2; exp_err = 1'b1; exp_dat = 32'h0; exp_cyc = 0; exp_sel = 3'b000;
    end else if (dly >= TO) begin
      exp_lat = TO + 2; exp_err = 1'b1; exp_dat = 32'h0; exp_cyc = TO;
    end else begin
      exp_lat = dly + 3; exp_err = 1'b0; exp_cyc = dly + 1;
      if (wr)         exp_dat = 32'h0;
      else if (in_dm) exp_dat = ref_mem[w];
      else if (in0)   exp_dat = dev0_dat;
      else            exp_dat = dev1_dat;
      if (wr && in_dm)
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[w][8*i +: 8] = wd[8*i +: 8];
    end

    cif.DAddr = addr; cif.DREn = rd; cif.DWEn = wr; cif.DByteEn = be; cif.DWData = wd;
    n = 1; cyc = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        chk("s_req_first", 32'(sif.s_req), 32'(exp_sel));
        if (legal) begin
          chk("s_addr", sif.s_addr, {addr[31:2], 2'b00});
          chk("s_wen", 32'(sif.s_wen), 32'(wr));
          chk("s_wdata", sif.s_wdata, wd);
          chk("s_byteen", 32'(sif.s_byteen), 32'(be));
        end
      end
      if (sif.s_req != 3'b000) cyc++;
      if (cif.DReady) got = 1'b1;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("DErr", 32'(cif.DErr), 32'(exp_err));
    chk("DRData", cif.DRData, exp_dat);
    chk("s_req_cycles", 32'(cyc), 32'(exp_cyc));

    cif.DREn = 1'b0; cif.DWEn = 1'b0; cif.DAddr = $urandom;
    @(negedge clk);
    chk("DReady_one_cycle", 32'(cif.DReady), 32'h0);
    chk("DRData_hold", cif.DRData, exp_dat);
    chk("DErr_hold", 32'(cif.DErr), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        rd, wr;
    int          k, r, dly;

    cif.DAddr = 32'h0; cif.DREn = 1'b0; cif.DWEn = 1'b0;
    cif.DByteEn = 4'h0; cif.DWData = 32'h0;
    dev_irq = 2'b11; ext_irq = 1'b1;

    // Reset state, with IRQ inputs active to show HWINT is held clear.
    repeat (3) @(negedge clk);
    chk("rst_DReady", 32'(cif.DReady), 32'h0);
    chk("rst_DErr", 32'(cif.DErr), 32'h0);
    chk("rst_DRData", cif.DRData, 32'h0);
    chk("rst_s_req", 32'(sif.s_req), 32'h0);
    chk("rst_s_wen", 32'(sif.s_wen), 32'h0);
    chk("rst_s_addr", sif.s_addr, 32'h0);
    chk("rst_s_byteen", 32'(sif.s_byteen), 32'h0);
    chk("rst_s_wdata", sif.s_wdata, 32'h0);
    chk("rst_HWINT", 32'(HWINT), 32'h0);
    reset = 1'b0; dev_irq = 2'b00; ext_irq = 1'b0;
    @(negedge clk);

    // Write then read back DM word 0x10 with a zero-wait slave.
    access(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0);
    access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0);
    // DEV1 read with four wait cycles.
    access(1'b1, 1'b0, D1 + 32'd8, 4'h0, 32'h0, 4);
    // Unmapped holes and window edges.
    access(1'b1, 1'b0, 32'h0000_5000, 4'h0, 32'h0, 0);
    access(1'b1, 1'b0, DM_TOP + 32'd1, 4'h0, 32'h0, 0);
    access(1'b1, 1'b0, D0 + 32'd12, 4'h0, 32'h0, 0);
    access(1'b1, 1'b0, D1 + 32'd12, 4'h0, 32'h0, 0);
    access(1'b1, 1'b0, 32'h0000_2FFC, 4'h0, 32'h0, 1);
    // Illegal write shapes.
    access(1'b0, 1'b1, D0, 4'b0011, 32'h1111_2222, 0);
    access(1'b1, 1'b1, 32'h10, 4'hF, 32'h3333_4444, 0);
    access(1'b0, 1'b1, 32'h20, 4'h0, 32'h5555_6666, 0);
    // Partial DM write merges into the earlier word.
    access(1'b0, 1'b1, 32'h10, 4'b0101, 32'h0011_2233, 2);
    access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0);
    // Timeout, and an ack in the last allowed wait cycle.
    access(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 100);
    access(1'b1, 1'b0, D0 + 32'd4, 4'h0, 32'h0, TO - 1);

    // Reset while in WAIT.
    ack_delay = 100; junk_ack = 3'b000;
    cif.DAddr = 32'h80; cif.DREn = 1'b1;
    repeat (3) @(negedge clk);
    chk("wait_s_req", 32'(sif.s_req), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wait_s_req", 32'(sif.s_req), 32'h0);
    chk("rst_wait_DReady", 32'(cif.DReady), 32'h0);
    cif.DREn = 1'b0; reset = 1'b0;
    @(negedge clk);

    dev_irq = 2'b10;
    @(negedge clk);
    chk("HWINT_dev1", 32'(HWINT), 32'h02);
    for (int i = 0; i < 6; i++) begin
      dev_irq = 2'($urandom_range(0, 3));
      ext_irq = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("HWINT_rand", 32'(HWINT), {26'h0, 3'b000, ext_irq, dev_irq});
    end

    // Random accesses across all windows, holes and op shapes.
    for (int t = 0; t < 80; t++) begin
      k = $urandom_range(0, 9);
      if (k < 3)      a = 32'($urandom_range(0, 15)) << 2;
      else if (k < 5) a = 32'h0000_2FC0 + (32'($urandom_range(0, 15)) << 2);
      else if (k < 7) a = D0 + (32'($urandom_range(0, 2)) << 2);
      else if (k < 8) a = D1 + (32'($urandom_range(0, 2)) << 2);
      else begin
        case ($urandom_range(0, 4))
          0: a = DM_TOP + 32'd1;
          1: a = D0 - 32'd4;
          2: a = D1 + 32'd12;
          3: a = 32'hFFFF_FFFC;
          default: a = 32'h0000_5000;
        endcase
      end
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      wd = $urandom;
      dly = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      access(rd, wr, a, be, wd, dly);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
